// File: rtl/exception_unit_pkg.sv
// Cause codes and FSM states shared by the exception unit and the fetch-side
// vector decoder.
package exception_unit_pkg;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'b00,
      CAUSE_INT  = 2'b01,
      CAUSE_OVF  = 2'b10,
      CAUSE_MEM  = 2'b11
   } cause_t;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      REQUEST = 2'b01,
      VECTOR  = 2'b10,
      HANDLER = 2'b11
   } state_t;

   // Request lines toward fetch, packed as {expt2, expt1, int}.
   function automatic logic [2:0] req_decode(input cause_t c);
      logic [2:0] r;
      r = '0;
      case (c)
         CAUSE_INT: r = 3'b001;
         CAUSE_OVF: r = 3'b010;
         CAUSE_MEM: r = 3'b100;
         default:   r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/exception_unit_irq_latch.sv
// Rising-edge capture of the external interrupt line; the pending flag holds
// until the exception unit takes the interrupt.
module irq_latch (
   input  logic clk,
   input  logic rst,
   input  logic irq,
   input  logic take,
   output logic pending
);

   logic irq_q;
   logic pend;

   // An edge in the current cycle is visible at once so IDLE can accept it.
   assign pending = pend | (irq & ~irq_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q <= 1'b0;
         pend  <= 1'b0;
      end else begin
         irq_q <= irq;
         pend  <= take ? 1'b0 : pending;
      end
   end

endmodule

// File: rtl/exception_unit.sv
// Exception/interrupt initiator: prioritises events, requests a vector from
// fetch, tracks the handler until rti, and supplies the return target.
module exception_unit
   import exception_unit_pkg::*;
#(
   parameter int ADDRWIDTH = 32,
   parameter int MAX_WAIT  = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 irq,
   input  logic                 ovf_expt,
   input  logic                 mem_expt,
   input  logic [ADDRWIDTH-1:0] expt_pc,
   input  logic [ADDRWIDTH-1:0] int_pc,
   input  logic                 extend,
   input  logic                 rti,
   output logic                 int_req,   // interrupt request line ("int" is a reserved word)
   output logic                 expt1,
   output logic                 expt2,
   output logic                 flush,
   output logic                 ret_jump,
   output logic [ADDRWIDTH-1:0] ret_target,
   output logic [ADDRWIDTH-1:0] epc,
   output logic [1:0]           cause,
   output logic                 hs_fault
);

   localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   state_t                 state_q, state_d;
   cause_t                 cause_q, cause_d;
   logic [ADDRWIDTH-1:0]   epc_q, epc_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   flush_q, flush_d;
   logic                   ret_q, ret_d;
   logic                   fault_q, fault_d;
   logic                   pending;
   logic                   take;
   logic [2:0]             req_lines;

   irq_latch u_irq (
      .clk     (clk),
      .rst     (rst),
      .irq     (irq),
      .take    (take),
      .pending (pending)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cause_q <= CAUSE_NONE;
         epc_q   <= '0;
         cnt_q   <= '0;
         flush_q <= 1'b0;
         ret_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         epc_q   <= epc_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
         ret_q   <= ret_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      epc_d   = epc_q;
      cnt_d   = cnt_q;
      flush_d = 1'b0;
      ret_d   = 1'b0;
      fault_d = fault_q;
      take    = 1'b0;

      case (state_q)
         IDLE: begin
            // A simultaneous overflow is younger and gets flushed, so no fault.
            if (mem_expt) begin
               cause_d = CAUSE_MEM;
               epc_d   = expt_pc;
               flush_d = 1'b1;
               cnt_d   = '0;
               state_d = REQUEST;
            end else if (ovf_expt) begin
               cause_d = CAUSE_OVF;
               epc_d   = expt_pc;
               flush_d = 1'b1;
               cnt_d   = '0;
               state_d = REQUEST;
            end else if (pending) begin
               cause_d = CAUSE_INT;
               epc_d   = int_pc;
               flush_d = 1'b1;
               cnt_d   = '0;
               take    = 1'b1;
               state_d = REQUEST;
            end
         end
         REQUEST: begin
            if (extend) begin
               state_d = VECTOR;
            end else if (cnt_q == CW'(MAX_WAIT)) begin
               fault_d = 1'b1;
               cause_d = CAUSE_NONE;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         VECTOR: begin
            if (!extend) state_d = HANDLER;
         end
         HANDLER: begin
            if (rti) begin
               ret_d   = 1'b1;
               cause_d = CAUSE_NONE;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && (mem_expt || ovf_expt)) fault_d = 1'b1;
   end

   // Requests are gated by rst so they fall in the same cycle reset is raised.
   assign req_lines  = (state_q == REQUEST && !rst) ? req_decode(cause_q) : 3'b000;
   assign int_req    = req_lines[0];
   assign expt1      = req_lines[1];
   assign expt2      = req_lines[2];
   assign flush      = flush_q;
   assign ret_jump   = ret_q;
   assign ret_target = epc_q;
   assign epc        = epc_q;
   assign cause      = cause_q;
   assign hs_fault   = fault_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit with hand-computed expected values.
module tb_exception_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        irq = 1'b0;
   logic        ovf_expt = 1'b0;
   logic        mem_expt = 1'b0;
   logic [31:0] expt_pc = '0;
   logic [31:0] int_pc = '0;
   logic        extend = 1'b0;
   logic        rti = 1'b0;
   logic        int_req, expt1, expt2, flush, ret_jump, hs_fault;
   logic [31:0] ret_target, epc;
   logic [1:0]  cause;

   int unsigned total = 0;
   int unsigned bad = 0;

   always #5 clk = ~clk;

   exception_unit #(.ADDRWIDTH(32), .MAX_WAIT(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .irq        (irq),
      .ovf_expt   (ovf_expt),
      .mem_expt   (mem_expt),
      .expt_pc    (expt_pc),
      .int_pc     (int_pc),
      .extend     (extend),
      .rti        (rti),
      .int_req    (int_req),
      .expt1      (expt1),
      .expt2      (expt2),
      .flush      (flush),
      .ret_jump   (ret_jump),
      .ret_target (ret_target),
      .epc        (epc),
      .cause      (cause),
      .hs_fault   (hs_fault)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".req"}, {29'd0, expt2, expt1, int_req}, 32'd0);
      chk({tag, ".flush"}, {31'd0, flush}, 32'd0);
      chk({tag, ".ret_jump"}, {31'd0, ret_jump}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;

      // Reset state
      step();
      step();
      chk_idle_outputs("rst");
      chk("rst.epc", epc, 32'd0);
      chk("rst.cause", {30'd0, cause}, 32'd0);
      chk("rst.fault", {31'd0, hs_fault}, 32'd0);
      rst = 1'b0;
      step();
      step();
      step();

      // Interrupt: edge accepted, request for 3 cycles, extend acknowledges
      irq = 1'b1;
      int_pc = 32'h100;
      step();
      chk("int.flush", {31'd0, flush}, 32'd1);
      chk("int.cause", {30'd0, cause}, 32'd1);
      chk("int.epc", epc, 32'h100);
      chk("int.req", {29'd0, expt2, expt1, int_req}, 32'b001);
      step();
      chk("int.flush_pulse", {31'd0, flush}, 32'd0);
      chk("int.req2", {31'd0, int_req}, 32'd1);
      step();
      extend = 1'b1;
      chk("int.req3", {31'd0, int_req}, 32'd1);
      step();
      chk("int.req_drop", {31'd0, int_req}, 32'd0);
      step();
      irq = 1'b0;
      step();
      extend = 1'b0;
      step();
      step();
      chk("vec.no_req", {29'd0, expt2, expt1, int_req}, 32'd0);

      // New irq edge in HANDLER, then rti: return first, interrupt next
      irq = 1'b1;
      int_pc = 32'h300;
      step();
      chk("hnd.no_req", {31'd0, int_req}, 32'd0);
      rti = 1'b1;
      step();
      rti = 1'b0;
      chk("rti.ret_jump", {31'd0, ret_jump}, 32'd1);
      chk("rti.target", ret_target, 32'h100);
      chk("rti.cause", {30'd0, cause}, 32'd0);
      chk("rti.no_req", {31'd0, int_req}, 32'd0);
      step();
      chk("nest.req", {31'd0, int_req}, 32'd1);
      chk("nest.flush", {31'd0, flush}, 32'd1);
      chk("nest.epc", epc, 32'h300);
      chk("nest.cause", {30'd0, cause}, 32'd1);
      chk("nest.ret_pulse", {31'd0, ret_jump}, 32'd0);
      extend = 1'b1;
      step();
      extend = 1'b0;
      step();
      step();
      rti = 1'b1;
      step();
      rti = 1'b0;
      chk("rti2.target", ret_target, 32'h300);
      irq = 1'b0;
      step();

      // mem and ovf together: memory wins, no fault
      mem_expt = 1'b1;
      ovf_expt = 1'b1;
      expt_pc = 32'h40;
      step();
      mem_expt = 1'b0;
      ovf_expt = 1'b0;
      chk("both.req", {29'd0, expt2, expt1, int_req}, 32'b100);
      chk("both.cause", {30'd0, cause}, 32'd3);
      chk("both.epc", epc, 32'h40);
      chk("both.fault", {31'd0, hs_fault}, 32'd0);
      extend = 1'b1;
      step();
      chk("both.req_drop", {31'd0, expt2}, 32'd0);

      // Overflow during VECTOR: dropped, fault, epc/cause kept
      ovf_expt = 1'b1;
      expt_pc = 32'h80;
      step();
      ovf_expt = 1'b0;
      chk("vecx.fault", {31'd0, hs_fault}, 32'd1);
      chk("vecx.epc", epc, 32'h40);
      chk("vecx.cause", {30'd0, cause}, 32'd3);
      chk("vecx.flush", {31'd0, flush}, 32'd0);
      extend = 1'b0;
      step();
      step();
      chk("vecx.no_req", {29'd0, expt2, expt1, int_req}, 32'd0);
      rti = 1'b1;
      step();
      rti = 1'b0;
      chk("vecx.ret", {31'd0, ret_jump}, 32'd1);

      // Clear the sticky fault before the timeout case
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("clr.fault", {31'd0, hs_fault}, 32'd0);
      step();

      // Timeout: expt1 held for MAX_WAIT+1 cycles
      ovf_expt = 1'b1;
      expt_pc = 32'h200;
      step();
      ovf_expt = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!expt1) break;
         n++;
         if (n < 16) chk("to.fault_early", {31'd0, hs_fault}, 32'd0);
         step();
      end
      chk("to.cycles", n, 32'd16);
      chk("to.fault", {31'd0, hs_fault}, 32'd1);
      chk("to.cause", {30'd0, cause}, 32'd0);

      // Back in IDLE: a memory exception is accepted
      mem_expt = 1'b1;
      expt_pc = 32'h44;
      step();
      mem_expt = 1'b0;
      chk("to.idle_req", {29'd0, expt2, expt1, int_req}, 32'b100);
      chk("to.idle_epc", epc, 32'h44);

      // irq edge while expt2 high, then reset mid-handshake
      irq = 1'b1;
      step();
      chk("mid.req", {31'd0, expt2}, 32'd1);
      rst = 1'b1;
      irq = 1'b0;
      #1;
      chk("mid.req_comb", {31'd0, expt2}, 32'd0);
      step();
      chk_idle_outputs("mid");
      chk("mid.epc", epc, 32'd0);
      chk("mid.cause", {30'd0, cause}, 32'd0);
      chk("mid.fault", {31'd0, hs_fault}, 32'd0);
      rst = 1'b0;
      rti = 1'b1;
      step();
      rti = 1'b0;
      chk("post.rti_ignored", {31'd0, ret_jump}, 32'd0);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (int_req || flush) n++;
      end
      chk("post.pend_clear", n, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
